cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
- Synthesizable run controller and PC trace capture unit for the multicycle CPU.
- Generalises the fixed bench sequence: wait, reset pulse, bounded run. Adds parametrised timing, a PC trace buffer of configurable depth with wrap or stop modes, halt detection and done reporting.
- Sits between the board/bench and the CPU instance. It drives the CPU reset and initPC, and samples PCout and the CPU state.

Parameters:
- PC_W, 32: PC width.
- DEPTH, 16: trace buffer entries. Must be a power of two, minimum 2.
- HOLD_CYC, 10: cycles spent in WAIT before the CPU reset pulse.
- PULSE_CYC, 1: cycles cpu_reset is held high.
- MAX_CYC, 100: RUN-cycle budget before timeout.
- STALL_LIM, 8: consecutive RUN cycles with an unchanged PC that declare a halt.
- FETCH_ST, 0: CPU state code in which the PC is captured.
- WRAP, 0: 0 = stop capturing when full (keep oldest); 1 = circular (keep newest).

Ports:
- clk, in, 1: clock, rising edge.
- reset, in, 1: asynchronous, active-low reset.
- start, in, 1: single-cycle run request.
- init_pc_cfg, in, PC_W: PC loaded into the CPU for this run.
- cpu_reset, out, 1: active-high reset to the CPU.
- initPC, out, PC_W: initial PC presented to the CPU.
- cpu_pc, in, PC_W: CPU PCout.
- cpu_state, in, 3: CPU FSM state.
- busy, out, 1: high in WAIT, PULSE and RUN.
- done, out, 1: high in DONE.
- done_cause, out, 2: 0 = none, 1 = timeout, 2 = halt, 3 = aborted.
- abort, in, 1: stop a run in progress.
- trace_cnt, out, clog2(DEPTH)+1: number of valid entries.
- trace_ovf, out, 1: a capture was dropped or overwrote an entry.
- rd_addr, in, clog2(DEPTH): trace read index. 0 is the oldest valid entry.
- rd_data, out, PC_W: combinational read of the entry at rd_addr.

Behaviour:
- Reset (reset = 0, asynchronous):
  - State = IDLE.
  - cpu_reset, busy, done and trace_ovf = 0.
  - done_cause = 0, trace_cnt = 0, initPC = 0.
  - All counters = 0. Buffer contents are don't-care.
- State machine:
  - IDLE: start = 1 latches init_pc_cfg into initPC, clears trace_cnt, trace_ovf and done_cause, then moves to WAIT.
  - WAIT: counts HOLD_CYC cycles, then moves to PULSE.
  - PULSE: cpu_reset = 1 for exactly PULSE_CYC cycles, then moves to RUN. cpu_reset is registered and deasserts on the same edge that enters RUN.
  - RUN:
    - cyc_cnt increments every cycle.
    - If cpu_state == FETCH_ST and cpu_pc differs from the last captured PC (or nothing has been captured yet this run), write cpu_pc to the buffer.
    - One capture per fetch visit. A held fetch state does not recapture the same PC.
  - DONE: holds all outputs. start = 1 behaves as in IDLE and begins a new run.
- Stall counter:
  - Resets to 0 whenever cpu_pc differs from its value the previous cycle.
  - Otherwise increments, saturating.
  - Reaching STALL_LIM moves RUN to DONE with cause 2.
- Timeout: cyc_cnt reaching MAX_CYC moves RUN to DONE with cause 1.
- abort = 1 in WAIT, PULSE or RUN moves to DONE with cause 3 and cpu_reset = 0 on the next edge. abort is ignored in IDLE and DONE.
- Priority when events coincide on one edge: abort > halt > timeout. A capture in that same cycle is still performed.
- start while busy is ignored.
- Buffer full, WRAP = 0: later captures are dropped and trace_ovf = 1. trace_cnt stays at DEPTH.
- Buffer full, WRAP = 1: the oldest entry is overwritten, the read base advances by 1 modulo DEPTH, trace_ovf = 1 and trace_cnt stays at DEPTH.
- Read port: rd_data = buf[(base + rd_addr) mod DEPTH]. It is undefined when rd_addr >= trace_cnt.
- A reset assertion mid-run returns to IDLE immediately and drops cpu_reset to 0.
- Latency:
  - start to cpu_reset rising is HOLD_CYC + 1 edges.
  - The halt or timeout condition to done = 1 is one edge.

Test Plan:
- Defaults, start with init_pc_cfg = 0: cpu_reset is high for 1 cycle, 11 edges after start. With a stub whose PC steps by 4 each fetch, done = 1 with cause 1 after 100 RUN cycles, trace_cnt = 16, trace_ovf = 1, and entries 0..15 are 0x00..0x3C.
- WRAP = 1 with the same stub: trace_cnt = 16 and entry 0 equals the 16th-from-last captured PC. The final entry equals the last PC fetched.
- Stub freezes PC at 0x20 after 5 fetches: done_cause = 2 exactly 8 cycles after the freeze, trace_cnt = 6, and no duplicate 0x20 entry.
- abort asserted in the 3rd WAIT cycle: next edge gives done = 1, cause 3, cpu_reset never pulsed and trace_cnt = 0.
- Halt and timeout in the same cycle gives cause 2. abort in that cycle as well gives cause 3.
- reset driven low mid-RUN, without a clock edge: state returns to IDLE, cpu_reset = 0 and busy = 0. A start while busy produces no restart. A start from DONE clears the trace and reruns.

Source files
------------

// File: rtl/cpu_run_ctrl_if.sv
// Link between the run controller and the CPU it supervises: the controller
// drives the CPU reset and start PC, the CPU reports its PC and FSM state.
interface cpu_run_ctrl_if #(
  parameter int PC_W = 32
);
  logic            cpu_reset;
  logic [PC_W-1:0] initPC;
  logic [PC_W-1:0] cpu_pc;
  logic [2:0]      cpu_state;

  modport master (
    output cpu_reset,
    output initPC,
    input  cpu_pc,
    input  cpu_state
  );

  modport slave (
    input  cpu_reset,
    input  initPC,
    output cpu_pc,
    output cpu_state
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run controller for the multicycle CPU: hold-off, reset pulse, bounded run
// with halt/timeout/abort detection, plus a PC trace buffer of fetched PCs.
module cpu_run_ctrl #(
  parameter int         PC_W      = 32,
  parameter int         DEPTH     = 16,
  parameter int         HOLD_CYC  = 10,
  parameter int         PULSE_CYC = 1,
  parameter int         MAX_CYC   = 100,
  parameter int         STALL_LIM = 8,
  parameter logic [2:0] FETCH_ST  = 3'd0,
  parameter bit         WRAP      = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [PC_W-1:0]          init_pc_cfg,
  cpu_run_ctrl_if.master           cpu,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               done_cause,
  output logic [$clog2(DEPTH):0]   trace_cnt,
  output logic                     trace_ovf,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [PC_W-1:0]          rd_data,
  output logic [2:0]               state_dbg
);

  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = AW + 1;
  localparam int PH_MAX  = (HOLD_CYC > PULSE_CYC) ? HOLD_CYC : PULSE_CYC;
  localparam int PHW     = $clog2(PH_MAX + 1);
  localparam int CYW     = $clog2(MAX_CYC + 1);
  localparam int STW     = $clog2(STALL_LIM + 1);

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd1;
  localparam logic [1:0] CAUSE_HALT    = 2'd2;
  localparam logic [1:0] CAUSE_ABORT   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_PULSE = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [PHW-1:0]  ph_cnt_q, ph_cnt_d;
  logic [CYW-1:0]  cyc_cnt_q, cyc_cnt_d;
  logic [STW-1:0]  stall_q, stall_d;
  logic [PC_W-1:0] prev_pc_q, prev_pc_d;
  logic [PC_W-1:0] last_cap_q, last_cap_d;
  logic            have_cap_q, have_cap_d;
  logic [PC_W-1:0] init_pc_q, init_pc_d;
  logic            cpu_reset_q, cpu_reset_d;
  logic [1:0]      cause_q, cause_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   base_q, base_d;
  logic            ovf_q, ovf_d;

  logic [PC_W-1:0] buf_q [DEPTH];
  logic            wr_en;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;
  logic            capture;
  logic            pc_moved;

  // A fetch is captured only when its PC differs from the previous capture,
  // so a CPU parked in fetch (or looping on one PC) adds a single entry.
  assign capture  = (state_q == S_RUN) && (cpu.cpu_state == FETCH_ST) &&
                    (!have_cap_q || (cpu.cpu_pc != last_cap_q));
  assign pc_moved = (cpu.cpu_pc != prev_pc_q);

  always_comb begin
    state_d     = state_q;
    ph_cnt_d    = ph_cnt_q;
    cyc_cnt_d   = cyc_cnt_q;
    stall_d     = stall_q;
    prev_pc_d   = cpu.cpu_pc;
    last_cap_d  = last_cap_q;
    have_cap_d  = have_cap_q;
    init_pc_d   = init_pc_q;
    cpu_reset_d = cpu_reset_q;
    cause_d     = cause_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    ovf_d       = ovf_q;
    wr_en       = 1'b0;
    wr_idx      = base_q + cnt_q[AW-1:0];

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_WAIT;
          init_pc_d  = init_pc_cfg;
          cnt_d      = '0;
          base_d     = '0;
          ovf_d      = 1'b0;
          cause_d    = CAUSE_NONE;
          have_cap_d = 1'b0;
          ph_cnt_d   = '0;
          cyc_cnt_d  = '0;
          stall_d    = '0;
        end
      end

      S_WAIT: begin
        if (abort) begin
          state_d = S_DONE;
          cause_d = CAUSE_ABORT;
        end else if (ph_cnt_q == PHW'(HOLD_CYC - 1)) begin
          state_d     = S_PULSE;
          ph_cnt_d    = '0;
          cpu_reset_d = 1'b1;
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end

      S_PULSE: begin
        if (abort) begin
          state_d     = S_DONE;
          cause_d     = CAUSE_ABORT;
          cpu_reset_d = 1'b0;
        end else if (ph_cnt_q == PHW'(PULSE_CYC - 1)) begin
          state_d     = S_RUN;
          ph_cnt_d    = '0;
          cpu_reset_d = 1'b0;
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end

      S_RUN: begin
        cyc_cnt_d = cyc_cnt_q + 1'b1;
        if (pc_moved) begin
          stall_d = '0;
        end else if (stall_q != STW'(STALL_LIM)) begin
          stall_d = stall_q + 1'b1;
        end

        if (capture) begin
          have_cap_d = 1'b1;
          last_cap_d = cpu.cpu_pc;
          if (cnt_q != CW'(DEPTH)) begin
            wr_en = 1'b1;
            cnt_d = cnt_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
            if (WRAP) begin
              // Full ring: overwrite the oldest slot and slide the read base.
              wr_en  = 1'b1;
              wr_idx = base_q;
              base_d = base_q + 1'b1;
            end
          end
        end

        if (abort) begin
          state_d = S_DONE;
          cause_d = CAUSE_ABORT;
        end else if (stall_d == STW'(STALL_LIM)) begin
          state_d = S_DONE;
          cause_d = CAUSE_HALT;
        end else if (cyc_cnt_d == CYW'(MAX_CYC)) begin
          state_d = S_DONE;
          cause_d = CAUSE_TIMEOUT;
        end
      end

      default: begin
        state_d     = S_IDLE;
        cpu_reset_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ph_cnt_q    <= '0;
      cyc_cnt_q   <= '0;
      stall_q     <= '0;
      prev_pc_q   <= '0;
      last_cap_q  <= '0;
      have_cap_q  <= 1'b0;
      init_pc_q   <= '0;
      cpu_reset_q <= 1'b0;
      cause_q     <= CAUSE_NONE;
      cnt_q       <= '0;
      base_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_cnt_q    <= ph_cnt_d;
      cyc_cnt_q   <= cyc_cnt_d;
      stall_q     <= stall_d;
      prev_pc_q   <= prev_pc_d;
      last_cap_q  <= last_cap_d;
      have_cap_q  <= have_cap_d;
      init_pc_q   <= init_pc_d;
      cpu_reset_q <= cpu_reset_d;
      cause_q     <= cause_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      ovf_q       <= ovf_d;
    end
  end

  // Trace storage carries no reset; entries past trace_cnt are never meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_q[wr_idx] <= cpu.cpu_pc;
    end
  end

  assign rd_idx        = base_q + rd_addr;
  assign rd_data       = buf_q[rd_idx];
  assign cpu.cpu_reset = cpu_reset_q;
  assign cpu.initPC    = init_pc_q;
  assign busy          = (state_q == S_WAIT) || (state_q == S_PULSE) || (state_q == S_RUN);
  assign done          = (state_q == S_DONE);
  assign done_cause    = cause_q;
  assign trace_cnt     = cnt_q;
  assign trace_ovf     = ovf_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: a CPU stub replays per-run PC/state programs into a
// stop-mode and a wrap-mode instance; an edge-indexed reference model predicts them.
module tb_cpu_run_ctrl;

  localparam int         PC_W      = 32;
  localparam int         DEPTH     = 16;
  localparam int         HOLD_CYC  = 10;
  localparam int         PULSE_CYC = 1;
  localparam int         MAX_CYC   = 100;
  localparam int         STALL_LIM = 8;
  localparam logic [2:0] FETCH_ST  = 3'd0;
  localparam int         AW        = $clog2(DEPTH);
  // Edge index (start edge = 1) of the last PULSE edge; RUN cycle k is sampled at edge PRE+1+k.
  localparam int         PRE       = 1 + HOLD_CYC + PULSE_CYC;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [PC_W-1:0] init_pc_cfg = '0;
  logic [PC_W-1:0] cpu_pc = '0;
  logic [2:0]      cpu_state = 3'd7;
  logic [AW-1:0]   rd_addr = '0;

  logic            busy0, done0, ovf0, busy1, done1, ovf1;
  logic [1:0]      cause0, cause1;
  logic [AW:0]     cnt0, cnt1;
  logic [PC_W-1:0] rd0, rd1;
  logic [2:0]      dbg0, dbg1;

  cpu_run_ctrl_if #(.PC_W(PC_W)) cif0 ();
  cpu_run_ctrl_if #(.PC_W(PC_W)) cif1 ();
  assign cif0.cpu_pc    = cpu_pc;
  assign cif0.cpu_state = cpu_state;
  assign cif1.cpu_pc    = cpu_pc;
  assign cif1.cpu_state = cpu_state;

  cpu_run_ctrl #(.PC_W(PC_W), .DEPTH(DEPTH), .HOLD_CYC(HOLD_CYC), .PULSE_CYC(PULSE_CYC),
    .MAX_CYC(MAX_CYC), .STALL_LIM(STALL_LIM), .FETCH_ST(FETCH_ST), .WRAP(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .init_pc_cfg(init_pc_cfg),
    .cpu(cif0), .busy(busy0), .done(done0), .done_cause(cause0), .trace_cnt(cnt0),
    .trace_ovf(ovf0), .rd_addr(rd_addr), .rd_data(rd0), .state_dbg(dbg0));

  cpu_run_ctrl #(.PC_W(PC_W), .DEPTH(DEPTH), .HOLD_CYC(HOLD_CYC), .PULSE_CYC(PULSE_CYC),
    .MAX_CYC(MAX_CYC), .STALL_LIM(STALL_LIM), .FETCH_ST(FETCH_ST), .WRAP(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .init_pc_cfg(init_pc_cfg),
    .cpu(cif1), .busy(busy1), .done(done1), .done_cause(cause1), .trace_cnt(cnt1),
    .trace_ovf(ovf1), .rd_addr(rd_addr), .rd_data(rd1), .state_dbg(dbg1));

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [PC_W-1:0] pc_a [MAX_CYC];
  logic [2:0]      st_a [MAX_CYC];
  logic [PC_W-1:0] pre_pc, init_pc;
  int              abort_j, dup_j;

  int              end_e, exp_cause, exp_cnt;
  bit              exp_ovf;
  logic [PC_W-1:0] exp_q0 [$];
  logic [PC_W-1:0] exp_q1 [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- stimulus programs ----------------
  // Multicycle CPU stub: each instruction spends n cycles in states 0..n-1,
  // PC advances by 4 per instruction; from hold_from on the PC is frozen.
  task automatic build_step(input logic [PC_W-1:0] pc0, input int n_lo, input int n_hi,
                            input int hold_from, input logic [PC_W-1:0] hold_pc);
    logic [PC_W-1:0] pc;
    int ph, n;
    pc = pc0;
    ph = 0;
    n  = $urandom_range(n_hi, n_lo);
    for (int k = 0; k < MAX_CYC; k++) begin
      pc_a[k] = (k >= hold_from) ? hold_pc : pc;
      st_a[k] = 3'(ph);
      ph++;
      if (ph == n) begin
        ph = 0;
        pc = pc + 4;
        n  = $urandom_range(n_hi, n_lo);
      end
    end
  endtask

  task automatic build_rand();
    for (int k = 0; k < MAX_CYC; k++) begin
      pc_a[k] = PC_W'($urandom_range(0, 3) * 4);
      st_a[k] = 3'($urandom_range(0, 3));
    end
  endtask

  // ---------------- reference model ----------------
  // Works on edge numbers: run ends at the earliest of abort / halt / timeout
  // edges (ties resolved abort, halt, timeout); captures are every fetch whose
  // PC differs from the previous capture, up to and including the end edge.
  task automatic model();
    logic [PC_W-1:0] capq [$];
    logic [PC_W-1:0] last, v;
    bit have, same;
    int halt_e, n;
    halt_e = PRE + MAX_CYC + 1;
    for (int k = STALL_LIM - 1; k < MAX_CYC && halt_e > PRE + MAX_CYC; k++) begin
      same = 1'b1;
      for (int i = k - STALL_LIM; i < k; i++) begin
        v = (i < 0) ? pre_pc : pc_a[i];
        if (v != pc_a[k]) same = 1'b0;
      end
      if (same) halt_e = PRE + 1 + k;
    end
    end_e     = PRE + MAX_CYC;
    exp_cause = 1;
    if (halt_e <= end_e) begin
      end_e     = halt_e;
      exp_cause = 2;
    end
    if (abort_j >= 2 && abort_j <= end_e) begin
      end_e     = abort_j;
      exp_cause = 3;
    end
    have = 1'b0;
    last = '0;
    for (int k = 0; k < MAX_CYC && PRE + 1 + k <= end_e; k++) begin
      if (st_a[k] == FETCH_ST && (!have || pc_a[k] != last)) begin
        capq.push_back(pc_a[k]);
        last = pc_a[k];
        have = 1'b1;
      end
    end
    n       = capq.size();
    exp_cnt = (n < DEPTH) ? n : DEPTH;
    exp_ovf = (n > DEPTH);
    exp_q0.delete();
    exp_q1.delete();
    for (int i = 0; i < exp_cnt; i++) begin
      exp_q0.push_back(capq[i]);
      exp_q1.push_back(capq[n - exp_cnt + i]);
    end
  endtask

  // ---------------- driver ----------------
  // Negedge j drives the inputs sampled at edge j and checks the state after edge j-1.
  // stop_j > 0 pulls reset low between clock edges at that negedge instead of finishing.
  task automatic run_case(input int stop_j);
    int k, e;
    model();
    dup_j = (end_e >= 3) ? int'($urandom_range(2, end_e - 1)) : 0;
    for (int j = 1; j <= end_e + 3; j++) begin
      @(negedge clk);
      if (j >= 2) begin
        e = j - 1;
        check("cpu_reset0", cif0.cpu_reset,
              (e >= HOLD_CYC + 1 && e <= HOLD_CYC + PULSE_CYC && e < end_e));
        check("cpu_reset1", cif1.cpu_reset,
              (e >= HOLD_CYC + 1 && e <= HOLD_CYC + PULSE_CYC && e < end_e));
        check("busy0", busy0, (e < end_e));
        check("busy1", busy1, (e < end_e));
        check("done0", done0, (e >= end_e));
      end
      if (j == stop_j) begin
        #2 reset = 1'b0;
        #1;
        check("rst_cpu_reset", cif0.cpu_reset, 1'b0);
        check("rst_busy", busy0, 1'b0);
        check("rst_done", done0, 1'b0);
        check("rst_cnt", cnt0, '0);
        check("rst_initpc", cif0.initPC, '0);
        check("rst_busy1", busy1, 1'b0);
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      start       = (j == 1) || (j == dup_j);
      abort       = (j == abort_j);
      init_pc_cfg = (j == 1) ? init_pc : PC_W'($urandom);
      k = j - PRE - 1;
      if (j <= PRE) begin
        cpu_pc    = pre_pc;
        cpu_state = 3'd7;
      end else if (k < MAX_CYC) begin
        cpu_pc    = pc_a[k];
        cpu_state = st_a[k];
      end else begin
        cpu_pc    = PC_W'($urandom);
        cpu_state = 3'($urandom_range(0, 7));
      end
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("end_done0", done0, 1'b1);
    check("end_done1", done1, 1'b1);
    check("cause0", cause0, exp_cause);
    check("cause1", cause1, exp_cause);
    check("cnt0", cnt0, exp_cnt);
    check("cnt1", cnt1, exp_cnt);
    check("ovf0", ovf0, exp_ovf);
    check("ovf1", ovf1, exp_ovf);
    check("initpc0", cif0.initPC, init_pc);
    for (int i = 0; i < exp_cnt; i++) begin
      rd_addr = AW'(i);
      #1;
      check("trace0", rd0, exp_q0[i]);
      check("trace1", rd1, exp_q1[i]);
    end
  endtask

  task automatic step_run(input logic [PC_W-1:0] pc0, input int n_lo, input int n_hi,
                          input int hold_from, input logic [PC_W-1:0] hold_pc, input int ab);
    init_pc = pc0;
    pre_pc  = pc0;
    abort_j = ab;
    build_step(pc0, n_lo, n_hi, hold_from, hold_pc);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("reset_cpu_reset", cif0.cpu_reset, 1'b0);
    check("reset_busy", busy0, 1'b0);
    check("reset_done", done0, 1'b0);
    check("reset_cause", cause0, 2'd0);
    check("reset_cnt", cnt0, '0);
    check("reset_ovf", ovf0, 1'b0);
    check("reset_initpc", cif0.initPC, '0);
    reset = 1'b1;
    @(negedge clk);

    // Defaults: PC steps by 4 every 4 cycles from 0, timeout after 100 RUN cycles.
    step_run('0, 4, 4, MAX_CYC, '0, 0);
    run_case(0);
    // PC frozen at 0x20 after five fetches: halt.
    step_run(32'h10, 4, 4, 16, 32'h20, 0);
    run_case(0);
    // Abort in the third WAIT cycle.
    step_run(32'h100, 3, 5, MAX_CYC, '0, 4);
    run_case(0);
    // Halt lands on the same edge as the timeout, then also with abort.
    step_run(32'h200, 3, 5, MAX_CYC - STALL_LIM - 1, 32'hFFFF_0000, 0);
    run_case(0);
    step_run(32'h200, 3, 5, MAX_CYC - STALL_LIM - 1, 32'hFFFF_0000, PRE + MAX_CYC);
    run_case(0);
    // Asynchronous reset during PULSE and during RUN, then a fresh run.
    step_run(32'h40, 3, 4, MAX_CYC, '0, 0);
    run_case(HOLD_CYC + 2);
    step_run(32'h40, 3, 4, MAX_CYC, '0, 0);
    run_case(PRE + 40);
    step_run(32'h80, 2, 5, MAX_CYC, '0, 0);
    run_case(0);

    for (int r = 0; r < 10; r++) begin
      init_pc = PC_W'($urandom) & ~PC_W'(3);
      if ($urandom_range(0, 2) != 0) begin
        pre_pc = init_pc;
        build_step(init_pc, 2, 5, $urandom_range(0, MAX_CYC + 20),
                   PC_W'($urandom_range(0, 15) * 4));
      end else begin
        pre_pc = PC_W'($urandom_range(0, 3) * 4);
        build_rand();
      end
      abort_j = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, PRE + MAX_CYC + 3)) : 0;
      run_case(0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
